// File: rtl/gpr_dump_pkg.sv
// Shared constants and dump FSM state encoding for the GPR debug reader.
package gpr_dump_pkg;

  localparam int GPR_NUM = 32;
  localparam int GPR_AW  = 5;
  localparam int GPR_DW  = 32;

  typedef enum logic [2:0] {
    DUMP_IDLE = 3'd0,
    DUMP_READ = 3'd1,
    DUMP_SEND = 3'd2,
    DUMP_CSUM = 3'd3,
    DUMP_DONE = 3'd4
  } dump_state_t;

endpackage

// File: rtl/gpr_dump.sv
// Walks the GPR file through the shared read port and streams each word on valid/ready.
// Define GPR_DUMP_CSUM_EN to append an XOR checksum beat after the last register.
module gpr_dump
  import gpr_dump_pkg::*;
#(
  parameter int NUM_REGS = GPR_NUM,
  parameter int ADDR_W   = GPR_AW,
  parameter int DATA_W   = GPR_DW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_sel,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_index,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_is_csum,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
`ifdef GPR_DUMP_CSUM_EN
  localparam dump_state_t AFTER_LAST = DUMP_CSUM;
`else
  localparam dump_state_t AFTER_LAST = DUMP_DONE;
`endif

  dump_state_t       state, state_n;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] index_q;
  logic [DATA_W-1:0] data_q;
  logic              handshake;
  logic              start_ok;
  logic              at_last;

  assign handshake = out_valid & out_ready;
  assign start_ok  = (state == DUMP_IDLE) & start & ~abort;
  assign at_last   = (idx == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= DUMP_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      index_q <= '0;
      data_q  <= '0;
    end else begin
      if (start_ok) idx <= '0;
      if (state == DUMP_READ) begin
        data_q  <= rd_data;
        index_q <= idx;
      end
      // idx saturates on the final register; the FSM leaves SEND instead of wrapping
      if (state == DUMP_SEND && handshake && !at_last) idx <= idx + ADDR_W'(1);
    end
  end

`ifdef GPR_DUMP_CSUM_EN
  logic [DATA_W-1:0] csum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  csum <= '0;
    else if (start_ok)                        csum <= '0;
    else if (state == DUMP_SEND && handshake) csum <= csum ^ data_q;
  end
`endif

  // abort overrides everything, including a start seen in IDLE
  always_comb begin
    state_n = state;
    case (state)
      DUMP_IDLE: if (start) state_n = DUMP_READ;
      DUMP_READ: state_n = DUMP_SEND;
      DUMP_SEND: if (handshake) state_n = at_last ? AFTER_LAST : DUMP_READ;
      DUMP_CSUM: if (handshake) state_n = DUMP_DONE;
      DUMP_DONE: state_n = DUMP_IDLE;
      default:   state_n = DUMP_IDLE;
    endcase
    if (abort) state_n = DUMP_IDLE;
  end

  always_comb begin
    rd_sel      = (state == DUMP_READ);
    rd_addr     = (state == DUMP_READ) ? idx : '0;
    out_valid   = (state == DUMP_SEND) || (state == DUMP_CSUM);
    out_index   = index_q;
    out_data    = data_q;
    busy        = (state != DUMP_IDLE);
    done        = (state == DUMP_DONE);
`ifdef GPR_DUMP_CSUM_EN
    out_last    = (state == DUMP_CSUM);
    out_is_csum = (state == DUMP_CSUM);
    if (state == DUMP_CSUM) begin
      out_index = '1;
      out_data  = csum;
    end
`else
    out_last    = (state == DUMP_SEND) && at_last;
    out_is_csum = 1'b0;
`endif
  end

endmodule

// File: tb/tb_gpr_dump.sv
// Scoreboard bench for gpr_dump: stimulus pushes expected beats, a negedge monitor pops them.
// Also covers the GPR_DUMP_CSUM_EN build when the macro is defined for both files.
module tb_gpr_dump;
  import gpr_dump_pkg::*;

  typedef struct {
    logic [4:0]  index;
    logic [31:0] data;
    logic        last;
    logic        is_csum;
    int          cyc;
  } beat_t;

`ifdef GPR_DUMP_CSUM_EN
  localparam int DONE_OFF = 66;
`else
  localparam int DONE_OFF = 65;
`endif

  logic        clk = 1'b0;
  logic        rst, start, abort, out_ready;
  logic [4:0]  rd_addr, out_index;
  logic        rd_sel, out_valid, out_last, out_is_csum, busy, done;
  logic [31:0] rd_data, out_data;
  logic [31:0] gpr [32];

  beat_t       sb[$];
  beat_t       mon_beat;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          done_count = 0;
  int          exp_done_cyc = -2;
  logic        hold_pending = 1'b0;
  logic [31:0] hold_data;
  logic [4:0]  hold_index;
  int          s;

  gpr_dump dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .rd_addr(rd_addr), .rd_sel(rd_sel), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .out_data(out_data), .out_last(out_last), .out_is_csum(out_is_csum),
    .busy(busy), .done(done)
  );

  assign rd_data = gpr[rd_addr];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic note_fail(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: got event, expected none (cycle %0d)", name, cyc);
  endtask

  // Handshakes are sampled mid-cycle, so they match what the next rising edge registers
  always @(negedge clk) begin
    if (out_valid) begin
      if (hold_pending) begin
        check_output("hold_data", out_data, hold_data);
        check_output("hold_index", out_index, hold_index);
      end
      if (out_ready) begin
        hold_pending = 1'b0;
        if (sb.size() == 0) note_fail("unexpected_beat");
        else begin
          mon_beat = sb.pop_front();
          check_output("beat_index", out_index, mon_beat.index);
          check_output("beat_data", out_data, mon_beat.data);
          check_output("beat_last", out_last, mon_beat.last);
          check_output("beat_is_csum", out_is_csum, mon_beat.is_csum);
          if (mon_beat.cyc >= 0) check_output("beat_cycle", cyc, mon_beat.cyc);
        end
      end else begin
        hold_pending = 1'b1;
        hold_data    = out_data;
        hold_index   = out_index;
      end
    end else begin
      hold_pending = 1'b0;
    end
    if (done) begin
      done_count++;
      if (exp_done_cyc == -2) note_fail("done_unexpected");
      else if (exp_done_cyc >= 0) check_output("done_cycle", cyc, exp_done_cyc);
    end
  end

  task automatic push_dump(input int start_cyc, input int n_beats, input bit full, input bit timed);
    logic [31:0] acc;
    acc = '0;
    for (int k = 0; k < n_beats; k++) begin
`ifdef GPR_DUMP_CSUM_EN
      sb.push_back('{5'(k), gpr[k], 1'b0, 1'b0, timed ? start_cyc + 2 + 2 * k : -1});
`else
      sb.push_back('{5'(k), gpr[k], (k == 31), 1'b0, timed ? start_cyc + 2 + 2 * k : -1});
`endif
      acc ^= gpr[k];
    end
`ifdef GPR_DUMP_CSUM_EN
    if (full) sb.push_back('{5'h1F, acc, 1'b1, 1'b1, timed ? start_cyc + 65 : -1});
`else
    if (full && acc == 32'hFFFF_FFFF) $display("[TB] note: all-ones fold of register image");
`endif
  endtask

  task automatic apply_stimulus();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_to(input int n);
    for (int g = 0; g < 2000 && cyc < n; g++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic finish_test(input string name, input int exp_dones);
    int g;
    for (g = 0; g < 400 && (busy || sb.size() != 0); g++) begin
      @(posedge clk); #1;
    end
    if (g >= 400) note_fail({name, "_timeout"});
    check_output({name, "_queue_empty"}, sb.size(), 0);
    check_output({name, "_done_count"}, done_count, exp_dones);
    @(posedge clk); #1;
    done_count   = 0;
    exp_done_cyc = -2;
  endtask

  task automatic preload_ramp();
    for (int i = 0; i < 32; i++) gpr[i] = 32'(i * 32'h11);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    preload_ramp();
    @(posedge clk); #1;
    check_output("rst_valid", out_valid, 0);
    check_output("rst_data", out_data, 0);
    check_output("rst_index", out_index, 0);
    check_output("rst_last", out_last, 0);
    check_output("rst_is_csum", out_is_csum, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_rd_sel", rd_sel, 0);
    check_output("rst_rd_addr", rd_addr, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // full dump with ready held high: beat every 2 cycles, done at fixed offset
    s = cyc;
    push_dump(s, 32, 1'b1, 1'b1);
    exp_done_cyc = s + DONE_OFF;
    apply_stimulus();
    finish_test("full", 1);

    // ready toggling: beats held while stalled, none lost or duplicated
    out_ready = 1'b0;
    s = cyc;
    push_dump(s, 32, 1'b1, 1'b0);
    exp_done_cyc = -1;
    apply_stimulus();
    for (int c = 0; c < 400 && busy; c++) begin
      @(posedge clk); #1;
      out_ready = ~out_ready;
    end
    out_ready = 1'b1;
    finish_test("toggle", 1);

    // abort on the handshake of idx 5; abort+start in IDLE must not start
    s = cyc;
    push_dump(s, 6, 1'b0, 1'b1);
    apply_stimulus();
    wait_to(s + 12);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check_output("abort_valid", out_valid, 0);
    check_output("abort_busy", busy, 0);
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check_output("abort_beats_start_busy", busy, 0);
    finish_test("abort", 0);

    // start while busy at idx 10 is ignored
    s = cyc;
    push_dump(s, 32, 1'b1, 1'b1);
    exp_done_cyc = s + DONE_OFF;
    apply_stimulus();
    wait_to(s + 22);
    apply_stimulus();
    finish_test("restart_ignored", 1);

    // reset in the SEND cycle of idx 7, then a clean restart from idx 0
    s = cyc;
    push_dump(s, 7, 1'b0, 1'b1);
    apply_stimulus();
    wait_to(s + 16);
    check_output("pre_rst_index", out_index, 7);
    rst = 1'b1;
    #1;
    check_output("mid_rst_valid", out_valid, 0);
    check_output("mid_rst_data", out_data, 0);
    check_output("mid_rst_index", out_index, 0);
    check_output("mid_rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    finish_test("reset_mid", 0);
    s = cyc;
    push_dump(s, 32, 1'b1, 1'b1);
    exp_done_cyc = s + DONE_OFF;
    apply_stimulus();
    finish_test("after_reset", 1);

`ifdef GPR_DUMP_CSUM_EN
    // checksum beat: 0xA5A5A5A5 ^ 0x0F0F0F0F = 0xAAAAAAAA
    for (int i = 0; i < 32; i++) gpr[i] = '0;
    gpr[1] = 32'hA5A5_A5A5;
    gpr[2] = 32'h0F0F_0F0F;
    s = cyc;
    push_dump(s, 32, 1'b0, 1'b1);
    sb.push_back('{5'h1F, 32'hAAAA_AAAA, 1'b1, 1'b1, s + 65});
    exp_done_cyc = s + 66;
    apply_stimulus();
    finish_test("csum", 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
